wb_pipe_stage: RTL and testbench
================================

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter RA_W, default 5: register-file address width.
REQ-003 Parameter CNT_W, default 64: retire-counter width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: the MEM stage presents an instruction.
REQ-007 Port in_ready, output, 1: the stage accepts an instruction this cycle.
REQ-008 Port stall, input, 1: hazard unit freezes WB.
REQ-009 Port flush, input, 1: squash the captured entry.
REQ-010 Ports pc_plus_4_in, alu_result_in, read_data_in, imm_in, inputs, XLEN each: the four candidate result sources.
REQ-011 Port rd_in, input, RA_W: destination register.
REQ-012 Port reg_write_in, input, 1: the instruction writes the register file.
REQ-013 Port result_src_in, input, 2: result select; 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-014 Port load_fmt_in, input, 3: RISC-V funct3 load format (LB, LH, LW, LBU, LHU; LD/LWU only when XLEN=64).
REQ-015 Port rf_we, output, 1: register-file write enable.
REQ-016 Port rf_waddr, output, RA_W: write address.
REQ-017 Port rf_wdata, output, XLEN: write-back data; also the forwarding source.
REQ-018 Port fwd_valid, output, 1: rf_wdata is valid for forwarding to EX.
REQ-019 Port load_misaligned, output, 1: single-cycle pulse flagging a misaligned load at retire.
REQ-020 Port instret, output, CNT_W: count of retired instructions.

Function
REQ-021 in_ready SHALL be ~stall; capture occurs when in_valid & in_ready.
REQ-022 On capture, all *_in fields SHALL be registered and wb_valid set to 1; if in_valid=0 while ready, wb_valid SHALL clear to 0.
REQ-023 While stall=1, the entry SHALL hold unchanged.
REQ-024 flush=1 SHALL clear wb_valid at the next edge, with priority over both stall and capture.
REQ-025 Retire SHALL occur when wb_valid & ~stall; latency from capture to retire is 1 cycle when there is no stall.
REQ-026 rf_we SHALL be retire & reg_write & (rd != 0) & ~misaligned, so each entry writes exactly once regardless of stall length.
REQ-027 rf_wdata SHALL be combinational from the registered entry through a 4:1 select on result_src.
REQ-028 For MEM select, the byte offset alu_result[1:0] (alu_result[2:0] when XLEN=64) SHALL pick the lane; LB/LH/LW SHALL sign-extend and LBU/LHU/LWU SHALL zero-extend to XLEN.
REQ-029 Misaligned SHALL mean a halfword at an odd offset, or a word/doubleword whose offset is not a multiple of its size; load_misaligned SHALL pulse on retire of such a MEM-select entry.
REQ-030 fwd_valid SHALL be wb_valid & reg_write & (rd != 0) & ~misaligned.
REQ-031 instret SHALL increment by 1 on each retire, wrap modulo 2^CNT_W, and not count flushed entries.

Reset
REQ-032 While reset=0: wb_valid, all registered fields and instret SHALL be 0; rf_we, fwd_valid and load_misaligned SHALL be 0; rf_wdata SHALL be 0.
REQ-033 Assertion mid-stall SHALL discard the held entry with no write issued.

Structure
REQ-034 Shared package wb_pkg SHALL hold the result_src encodings, the load funct3 encodings and the default XLEN.
REQ-035 Sub-module load_align (combinational: data, offset, fmt -> aligned data, misaligned) SHALL perform the lane extraction and misalignment check.

Verification
REQ-036 ALU path: alu=A5A5A5A5, rd=10, src=00, 1 cycle -> rf_we=1, waddr=10, wdata=A5A5A5A5, instret=1.
REQ-037 Loads: read_data=87654321, LB offset 3 -> FFFFFF87; LBU offset 3 -> 00000087; LH offset 2 -> FFFF8765; LH offset 1 -> load_misaligned=1, rf_we=0.
REQ-038 Stall 3 cycles on a PC+4 entry (pc+4=00000004, rd=1) -> exactly one rf_we pulse, after stall drops; instret +1; in_ready=0 during the stall.
REQ-039 flush together with stall and in_valid -> wb_valid=0, no write, instret unchanged.
REQ-040 rd=0 with reg_write=1 -> rf_we=0, fwd_valid=0, instret +1.
REQ-041 reset=0 during a held stall, then CNT_W=8 run of 257 retires -> all outputs 0 during reset; instret=1 after the run.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
// Contents:
//   XLEN_DEFAULT  - default datapath width
//   result_src_e  - result select encodings (ALU / MEM / PC+4 / IMM)
//   load_fmt_e    - RISC-V load funct3 encodings
//   off_w()       - byte-offset width for a given datapath width
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10,
        SRC_IMM = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_D  = 3'b011,
        LD_BU = 3'b100,
        LD_HU = 3'b101,
        LD_WU = 3'b110
    } load_fmt_e;

    // A 64-bit datapath needs three offset bits to address eight byte lanes.
    function automatic int off_w(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction and misalignment detection (purely combinational).
// Ports:
//   data       in  XLEN   raw word read from memory
//   offset     in  OFF_W  byte offset of the access (low address bits)
//   fmt        in  3      load funct3
//   aligned    out XLEN   selected lane, sign- or zero-extended to XLEN
//   misaligned out 1      access size does not divide the offset
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int OFF_W = off_w(XLEN)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       fmt,
    output logic [XLEN-1:0]  aligned,
    output logic             misaligned
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        // Bring the addressed byte lane down to bit 0.
        shifted    = data >> {offset, 3'b000};
        aligned    = shifted;
        misaligned = 1'b0;
        case (load_fmt_e'(fmt))
            LD_B:  aligned = XLEN'($signed(shifted[7:0]));
            LD_BU: aligned = XLEN'(shifted[7:0]);
            LD_H: begin
                aligned    = XLEN'($signed(shifted[15:0]));
                misaligned = offset[0];
            end
            LD_HU: begin
                aligned    = XLEN'(shifted[15:0]);
                misaligned = offset[0];
            end
            LD_W: begin
                aligned    = XLEN'($signed(shifted[31:0]));
                misaligned = (offset[1:0] != 2'b00);
            end
            LD_WU: begin
                aligned    = XLEN'(shifted[31:0]);
                misaligned = (offset[1:0] != 2'b00);
            end
            LD_D: begin
                aligned    = shifted;
                misaligned = (offset != '0);
            end
            default: aligned = shifted;
        endcase
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: holds one instruction from MEM, selects its
// result, writes the register file once and counts retired instructions.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready              MEM -> WB handshake
//   stall, flush                   hazard-unit controls
//   pc_plus_4_in, alu_result_in,
//   read_data_in, imm_in           candidate result sources
//   rd_in, reg_write_in,
//   result_src_in, load_fmt_in     control fields of the instruction
//   rf_we, rf_waddr, rf_wdata      register-file write port (wdata also forwards)
//   fwd_valid                      rf_wdata is usable by EX
//   load_misaligned                one-cycle pulse at retire of a bad load
//   instret                        retired-instruction counter
//
// Handshake: in_ready = ~stall. An instruction transfers on a rising edge
// where in_valid & in_ready. When ready with in_valid low the stage empties.
// While stalled the held entry stays put. flush empties the stage at the next
// edge and overrides both stall and a transfer.
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  pc_plus_4_in,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [XLEN-1:0]  read_data_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [RA_W-1:0]  rd_in,
    input  logic             reg_write_in,
    input  logic [1:0]       result_src_in,
    input  logic [2:0]       load_fmt_in,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic             load_misaligned,
    output logic [CNT_W-1:0] instret
);

    localparam int OFF_W = off_w(XLEN);

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        result_src_e     src;
        logic [2:0]      fmt;
    } entry_t;

    entry_t           entry_d, entry_q;
    logic             wb_valid_d, wb_valid_q;
    logic [CNT_W-1:0] instret_d, instret_q;

    logic             retire;
    logic [XLEN-1:0]  load_data;
    logic             align_mis;
    logic             bad_load;
    logic             writes_rf;

    assign in_ready = ~stall;
    assign retire   = wb_valid_q & ~stall;

    always_comb begin
        entry_d    = entry_q;
        wb_valid_d = wb_valid_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            wb_valid_d = in_valid;
            if (in_valid) begin
                entry_d.pc4       = pc_plus_4_in;
                entry_d.alu       = alu_result_in;
                entry_d.rdata     = read_data_in;
                entry_d.imm       = imm_in;
                entry_d.rd        = rd_in;
                entry_d.reg_write = reg_write_in;
                entry_d.src       = result_src_e'(result_src_in);
                entry_d.fmt       = load_fmt_in;
            end
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q    <= '0;
            wb_valid_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            entry_q    <= entry_d;
            wb_valid_q <= wb_valid_d;
            instret_q  <= instret_d;
        end
    end

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .data       (entry_q.rdata),
        .offset     (entry_q.alu[OFF_W-1:0]),
        .fmt        (entry_q.fmt),
        .aligned    (load_data),
        .misaligned (align_mis)
    );

    // Misalignment only matters when the result actually comes from memory.
    assign bad_load  = (entry_q.src == SRC_MEM) & align_mis;
    assign writes_rf = entry_q.reg_write & (entry_q.rd != '0) & ~bad_load;

    always_comb begin
        rf_wdata = entry_q.alu;
        case (entry_q.src)
            SRC_ALU: rf_wdata = entry_q.alu;
            SRC_MEM: rf_wdata = load_data;
            SRC_PC4: rf_wdata = entry_q.pc4;
            SRC_IMM: rf_wdata = entry_q.imm;
            default: rf_wdata = entry_q.alu;
        endcase
    end

    // Write only on the retire cycle so a long stall still yields one write.
    assign rf_we           = retire & writes_rf;
    assign rf_waddr        = entry_q.rd;
    assign fwd_valid       = wb_valid_q & writes_rf;
    assign load_misaligned = retire & bad_load;
    assign instret         = instret_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
module tb_wb_pipe_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, stall, flush;
    logic [31:0] pc_plus_4_in, alu_result_in, read_data_in, imm_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic [1:0]  result_src_in;
    logic [2:0]  load_fmt_in;

    logic        in_ready, rf_we, fwd_valid, load_misaligned;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] instret;

    logic        in_ready8, rf_we8, fwd_valid8, load_misaligned8;
    logic [4:0]  rf_waddr8;
    logic [31:0] rf_wdata8;
    logic [7:0]  instret8;

    wb_pipe_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .pc_plus_4_in(pc_plus_4_in),
        .alu_result_in(alu_result_in), .read_data_in(read_data_in),
        .imm_in(imm_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .result_src_in(result_src_in), .load_fmt_in(load_fmt_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .load_misaligned(load_misaligned),
        .instret(instret)
    );

    wb_pipe_stage #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .stall(stall), .flush(flush), .pc_plus_4_in(pc_plus_4_in),
        .alu_result_in(alu_result_in), .read_data_in(read_data_in),
        .imm_in(imm_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .result_src_in(result_src_in), .load_fmt_in(load_fmt_in),
        .rf_we(rf_we8), .rf_waddr(rf_waddr8), .rf_wdata(rf_wdata8),
        .fwd_valid(fwd_valid8), .load_misaligned(load_misaligned8),
        .instret(instret8)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // One slot holding the last accepted instruction, plus a retire count.
    bit              m_valid;
    logic [31:0]     m_pc, m_alu, m_rdata, m_imm;
    logic [4:0]      m_rd;
    bit              m_rw;
    logic [1:0]      m_src;
    logic [2:0]      m_fmt;
    longint unsigned m_count;

    function automatic logic [31:0] exp_load(input logic [31:0] data, input int off,
                                             input logic [2:0] fmt);
        longint v;
        int     nbytes;
        bit     sgn;
        case (fmt)
            3'd0:    begin nbytes = 1; sgn = 1; end
            3'd1:    begin nbytes = 2; sgn = 1; end
            3'd2:    begin nbytes = 4; sgn = 1; end
            3'd4:    begin nbytes = 1; sgn = 0; end
            3'd5:    begin nbytes = 2; sgn = 0; end
            default: begin nbytes = 4; sgn = 0; end
        endcase
        v = (longint'(data) >> (8 * off)) % (longint'(1) << (8 * nbytes));
        if (sgn && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic bit exp_mis(input int off, input logic [2:0] fmt);
        if (fmt == 3'd1 || fmt == 3'd5) return (off % 2) != 0;
        if (fmt == 3'd2) return (off % 4) != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_alu = 0; m_rdata = 0; m_imm = 0;
        m_rd = 0; m_rw = 0; m_src = 0; m_fmt = 0; m_count = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            if (m_valid && !stall) m_count++;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = in_valid;
                if (in_valid) begin
                    m_pc = pc_plus_4_in; m_alu = alu_result_in; m_rdata = read_data_in;
                    m_imm = imm_in; m_rd = rd_in; m_rw = reg_write_in;
                    m_src = result_src_in; m_fmt = load_fmt_in;
                end
            end
        end
    endtask

    task automatic compare_model();
        bit          ret, bad, wr;
        logic [31:0] exp_data;
        ret = m_valid && !stall;
        bad = (m_src == 2'd1) && exp_mis(int'(m_alu[1:0]), m_fmt);
        wr  = m_rw && (m_rd != 0) && !bad;
        case (m_src)
            2'd0:    exp_data = m_alu;
            2'd1:    exp_data = exp_load(m_rdata, int'(m_alu[1:0]), m_fmt);
            2'd2:    exp_data = m_pc;
            default: exp_data = m_imm;
        endcase
        check("in_ready", in_ready, !stall);
        check("rf_we", rf_we, ret && wr);
        check("fwd_valid", fwd_valid, m_valid && wr);
        check("load_misaligned", load_misaligned, ret && bad);
        check("instret", instret, m_count);
        check("instret8", instret8, m_count % 256);
        if (m_valid) begin
            check("rf_waddr", rf_waddr, m_rd);
            if (!bad) check("rf_wdata", rf_wdata, exp_data);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit st, input bit fl,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] imm,
                         input logic [4:0] rd, input bit rw,
                         input logic [1:0] src, input logic [2:0] fmt);
        in_valid = v; stall = st; flush = fl;
        pc_plus_4_in = pc; alu_result_in = alu; read_data_in = rdata; imm_in = imm;
        rd_in = rd; reg_write_in = rw; result_src_in = src; load_fmt_in = fmt;
    endtask

    task automatic drive_idle(input bit st);
        drive(1'b0, st, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0);
    endtask

    task automatic drive_rand();
        logic [2:0] legal_fmt[5];
        bit st;
        legal_fmt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st = ($urandom_range(0, 3) == 0);
        drive($urandom_range(0, 9) < 7, st, st && ($urandom_range(0, 2) == 0),
              $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
              $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              legal_fmt[$urandom_range(0, 4)]);
    endtask

    // Caller has let the inputs settle; compare, then advance one edge.
    task automatic cycle();
        compare_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        #1;
        cycle();
    endtask

    longint unsigned base;
    int              guard;

    initial begin
        // ---- reset state ----
        reset = 1'b0;
        drive_idle(1'b0);
        model_reset();
        #3;
        check("rst rf_we", rf_we, 0);
        check("rst fwd_valid", fwd_valid, 0);
        check("rst load_misaligned", load_misaligned, 0);
        check("rst rf_wdata", rf_wdata, 0);
        check("rst instret", instret, 0);
        cycle();
        reset = 1'b1;

        // ---- ALU path ----
        drive(1, 0, 0, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd10, 1, 2'd0, 3'd0);
        step();
        drive_idle(1'b0);
        #1;
        check("alu rf_we", rf_we, 1);
        check("alu rf_waddr", rf_waddr, 10);
        check("alu rf_wdata", rf_wdata, 32'hA5A5A5A5);
        cycle();
        check("alu instret", instret, 1);

        // ---- load lane selection and extension ----
        drive(1, 0, 0, 32'h0, 32'h1003, 32'h87654321, 32'h0, 5'd5, 1, 2'd1, 3'd0);
        step();
        drive(1, 0, 0, 32'h0, 32'h1003, 32'h87654321, 32'h0, 5'd5, 1, 2'd1, 3'd4);
        #1;
        check("lb off3", rf_wdata, 32'hFFFFFF87);
        check("lb rf_we", rf_we, 1);
        cycle();
        drive(1, 0, 0, 32'h0, 32'h1002, 32'h87654321, 32'h0, 5'd5, 1, 2'd1, 3'd1);
        #1;
        check("lbu off3", rf_wdata, 32'h00000087);
        cycle();
        drive(1, 0, 0, 32'h0, 32'h1001, 32'h87654321, 32'h0, 5'd5, 1, 2'd1, 3'd1);
        #1;
        check("lh off2", rf_wdata, 32'hFFFF8765);
        cycle();
        drive_idle(1'b0);
        #1;
        check("lh off1 misaligned", load_misaligned, 1);
        check("lh off1 rf_we", rf_we, 0);
        cycle();

        // ---- PC+4 entry held by a 3-cycle stall ----
        drive(1, 0, 0, 32'h00000004, 32'h0, 32'h0, 32'h0, 5'd1, 1, 2'd2, 3'd0);
        step();
        base = m_count;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h0, 32'h11, 32'h0, 32'h0, 5'd7, 1, 2'd0, 3'd0);
            #1;
            check("stall in_ready", in_ready, 0);
            check("stall rf_we", rf_we, 0);
            cycle();
        end
        drive_idle(1'b0);
        #1;
        check("stall release rf_we", rf_we, 1);
        check("stall release rf_wdata", rf_wdata, 32'h00000004);
        cycle();
        check("stall instret", instret, base + 1);
        #1;
        check("stall single write", rf_we, 0);
        cycle();

        // ---- flush beats stall and capture ----
        drive(1, 0, 0, 32'h0, 32'h22, 32'h0, 32'h0, 5'd9, 1, 2'd0, 3'd0);
        step();
        base = m_count;
        drive(1, 1, 1, 32'h0, 32'h33, 32'h0, 32'h0, 5'd9, 1, 2'd0, 3'd0);
        step();
        drive_idle(1'b0);
        #1;
        check("flush fwd_valid", fwd_valid, 0);
        check("flush rf_we", rf_we, 0);
        cycle();
        check("flush instret", instret, base);

        // ---- rd = 0 retires without writing ----
        drive(1, 0, 0, 32'h0, 32'h44, 32'h0, 32'h0, 5'd0, 1, 2'd0, 3'd0);
        step();
        base = m_count;
        drive_idle(1'b0);
        #1;
        check("x0 rf_we", rf_we, 0);
        check("x0 fwd_valid", fwd_valid, 0);
        cycle();
        check("x0 instret", instret, base + 1);

        // ---- randomized traffic ----
        for (int i = 0; i < 200; i++) begin
            drive_rand();
            step();
        end

        // ---- reset during a held stall, then wrap the 8-bit counter ----
        drive(1, 0, 0, 32'h00000040, 32'h0, 32'h0, 32'h0, 5'd3, 1, 2'd2, 3'd0);
        step();
        drive_idle(1'b1);
        step();
        reset = 1'b0;
        model_reset();
        #1;
        check("mid-stall rst rf_we", rf_we, 0);
        check("mid-stall rst fwd_valid", fwd_valid, 0);
        check("mid-stall rst load_misaligned", load_misaligned, 0);
        check("mid-stall rst rf_wdata", rf_wdata, 0);
        check("mid-stall rst instret", instret, 0);
        check("mid-stall rst instret8", instret8, 0);
        cycle();
        reset = 1'b1;
        guard = 0;
        while (m_count < 257 && guard < 600) begin
            drive(1, 0, 0, $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1, 2'd0, 3'd0);
            step();
            guard++;
        end
        check("wrap run completed", m_count, 257);
        check("wrap instret8", instret8, 1);
        check("wrap instret", instret, 257);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
